// File: rtl/time_display_scanner_pkg.sv
// Shared types and constants for the multiplexed time display scanner.
package time_display_scanner_pkg;

   typedef enum logic [1:0] {
      LATCH   = 2'd0,
      CONVERT = 2'd1,
      SCAN    = 2'd2
   } state_t;

   localparam int unsigned NUM_DIGITS = 8;
   localparam logic [6:0]  SEG_BLANK  = 7'h7F;

   // Active-low segment patterns, bit0 = a ... bit6 = g
   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;

   typedef struct packed {
      logic [4:0] hours;
      logic [5:0] minutes;
      logic [5:0] seconds;
      logic [6:0] hundredths;
      logic       ring;
   } snapshot_t;

   // Binary field to {tens, ones} BCD, saturating at 99
   function automatic logic [7:0] to_bcd(input logic [6:0] value);
      logic [6:0] v;
      v = (value > 7'd99) ? 7'd99 : value;
      return {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

endpackage

// File: rtl/time_display_scanner_seven_seg.sv
// Combinational BCD to active-low seven-segment decoder with blanking.
module seven_seg_encoder
   import time_display_scanner_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] segments
);

   always_comb begin
      segments = SEG_BLANK;
      if (!blank) begin
         case (bcd)
            4'd0:    segments = SEG_0;
            4'd1:    segments = SEG_1;
            4'd2:    segments = SEG_2;
            4'd3:    segments = SEG_3;
            4'd4:    segments = SEG_4;
            4'd5:    segments = SEG_5;
            4'd6:    segments = SEG_6;
            4'd7:    segments = SEG_7;
            4'd8:    segments = SEG_8;
            4'd9:    segments = SEG_9;
            default: segments = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/time_display_scanner.sv
// Eight-digit multiplexed time display: latch inputs, convert to BCD, scan digits.
// Outputs are registered from the current state, so they trail the state by one cycle.
module time_display_scanner
   import time_display_scanner_pkg::*;
#(
   parameter int unsigned SCAN_DIVIDE  = 1000,
   parameter int unsigned BLINK_FRAMES = 32
) (
   input  logic       clockSignal,
   input  logic       reset,
   input  logic [4:0] timeInHoursDisplay,
   input  logic [5:0] timeInMinutesDisplay,
   input  logic [5:0] timeInSeconds,
   input  logic [6:0] millisecondsDisplay,
   input  logic       ringSound,
   output logic [7:0] anodeSelect,
   output logic [6:0] segments,
   output logic       decimalPoint,
   output logic       frameStart
);

   localparam int unsigned SCAN_W  = (SCAN_DIVIDE > 1) ? $clog2(SCAN_DIVIDE) : 1;
   localparam int unsigned FRAME_W = $clog2(2 * BLINK_FRAMES);
   localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);

   state_t                         state;
   snapshot_t                      snap;
   logic [NUM_DIGITS-1:0][3:0]     digits;
   logic [1:0]                     conv_cnt;
   logic [SCAN_W-1:0]              scan_cnt;
   logic [IDX_W-1:0]               digit_idx;
   logic [FRAME_W-1:0]             frame_cnt;

   logic [3:0] cur_digit;
   logic       cur_blank;
   logic       lit;
   logic       dp_digit;
   logic [6:0] enc_seg;

   assign cur_digit = digits[digit_idx];
   // Leading zero of the hours field is suppressed
   assign cur_blank = (digit_idx == IDX_W'(NUM_DIGITS - 1)) && (cur_digit == 4'd0);
   assign lit       = (scan_cnt != '0) &&
                      !(snap.ring && (frame_cnt >= FRAME_W'(BLINK_FRAMES)));
   assign dp_digit  = (digit_idx == IDX_W'(2)) || (digit_idx == IDX_W'(4)) ||
                      (digit_idx == IDX_W'(6));

   seven_seg_encoder u_enc (
      .bcd      (cur_digit),
      .blank    (cur_blank),
      .segments (enc_seg)
   );

   always_ff @(posedge clockSignal) begin
      if (reset) begin
         state        <= LATCH;
         snap         <= '0;
         digits       <= '0;
         conv_cnt     <= '0;
         scan_cnt     <= '0;
         digit_idx    <= '0;
         frame_cnt    <= '0;
         anodeSelect  <= 8'hFF;
         segments     <= SEG_BLANK;
         decimalPoint <= 1'b1;
         frameStart   <= 1'b0;
      end else begin
         anodeSelect  <= 8'hFF;
         segments     <= SEG_BLANK;
         decimalPoint <= 1'b1;
         frameStart   <= 1'b0;
         case (state)
            LATCH: begin
               snap.hours      <= timeInHoursDisplay;
               snap.minutes    <= timeInMinutesDisplay;
               snap.seconds    <= timeInSeconds;
               snap.hundredths <= millisecondsDisplay;
               snap.ring       <= ringSound;
               frameStart      <= 1'b1;
               conv_cnt        <= '0;
               state           <= CONVERT;
            end
            CONVERT: begin
               case (conv_cnt)
                  2'd0:    digits[1:0] <= to_bcd(snap.hundredths);
                  2'd1:    digits[3:2] <= to_bcd(7'(snap.seconds));
                  2'd2:    digits[5:4] <= to_bcd(7'(snap.minutes));
                  default: digits[7:6] <= to_bcd(7'(snap.hours));
               endcase
               if (conv_cnt == 2'd3) begin
                  scan_cnt  <= '0;
                  digit_idx <= '0;
                  state     <= SCAN;
               end else begin
                  conv_cnt <= conv_cnt + 2'd1;
               end
            end
            SCAN: begin
               // First cycle of each slot stays dark to avoid ghosting
               if (lit) begin
                  anodeSelect  <= ~(8'h01 << digit_idx);
                  segments     <= enc_seg;
                  decimalPoint <= !dp_digit;
               end
               if (scan_cnt == SCAN_W'(SCAN_DIVIDE - 1)) begin
                  scan_cnt <= '0;
                  if (digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
                     state     <= LATCH;
                     frame_cnt <= (frame_cnt == FRAME_W'(2 * BLINK_FRAMES - 1)) ?
                                  '0 : frame_cnt + FRAME_W'(1);
                  end else begin
                     digit_idx <= digit_idx + IDX_W'(1);
                  end
               end else begin
                  scan_cnt <= scan_cnt + SCAN_W'(1);
               end
            end
            default: state <= LATCH;
         endcase
      end
   end

endmodule

// File: tb/tb_time_display_scanner.sv
// Scoreboard bench: expected output cycles of each frame are queued, then popped per cycle.
module tb_time_display_scanner;

   localparam int FRAME_LEN = 37;

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fs;
   } out_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] hours;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic [6:0] hundredths;
   logic       ring;
   logic [7:0] anodeSelect;
   logic [6:0] segments;
   logic       decimalPoint;
   logic       frameStart;

   int   checks   = 0;
   int   failures = 0;
   int   fidx     = 0;
   out_t exp_q[$];

   always #5 clk = ~clk;

   time_display_scanner #(.SCAN_DIVIDE(4), .BLINK_FRAMES(2)) dut (
      .clockSignal          (clk),
      .reset                (reset),
      .timeInHoursDisplay   (hours),
      .timeInMinutesDisplay (minutes),
      .timeInSeconds        (seconds),
      .millisecondsDisplay  (hundredths),
      .ringSound            (ring),
      .anodeSelect          (anodeSelect),
      .segments             (segments),
      .decimalPoint         (decimalPoint),
      .frameStart           (frameStart)
   );

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic out_t idle_out();
      out_t o;
      o = {8'hFF, 7'h7F, 1'b1, 1'b0};
      return o;
   endfunction

   task automatic check(input string tag, input out_t obs, input out_t exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Queue one whole frame as seen on the outputs, starting at the frameStart cycle
   task automatic push_frame(input int h, input int m, input int s, input int ms,
                             input bit rg, input int fnum);
      int         v[8];
      int         msc;
      bit         dark;
      out_t       o;
      logic [7:0] one;
      one  = 8'h01;
      msc  = (ms > 99) ? 99 : ms;
      v[0] = msc % 10; v[1] = msc / 10;
      v[2] = s % 10;   v[3] = s / 10;
      v[4] = m % 10;   v[5] = m / 10;
      v[6] = h % 10;   v[7] = h / 10;
      dark = rg && ((fnum % 4) >= 2);
      o = {8'hFF, 7'h7F, 1'b1, 1'b1};
      exp_q.push_back(o);
      for (int i = 0; i < 4; i++) exp_q.push_back(idle_out());
      for (int k = 0; k < 8; k++) begin
         exp_q.push_back(idle_out());
         for (int j = 0; j < 3; j++) begin
            if (dark) begin
               exp_q.push_back(idle_out());
            end else begin
               o.an  = ~(one << k);
               o.seg = (k == 7 && v[7] == 0) ? 7'h7F : seg_of(v[k]);
               o.dp  = !(k == 2 || k == 4 || k == 6);
               o.fs  = 1'b0;
               exp_q.push_back(o);
            end
         end
      end
   endtask

   task automatic run(input int n, input string tag);
      out_t obs;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
         obs = {anodeSelect, segments, decimalPoint, frameStart};
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s queue_empty observed=%h", tag, obs);
         end else begin
            check($sformatf("%s_f%0d_c%0d", tag, fidx, i), obs, exp_q.pop_front());
         end
      end
   endtask

   task automatic frame(input string tag);
      push_frame(int'(hours), int'(minutes), int'(seconds), int'(hundredths), ring, fidx);
      run(FRAME_LEN, tag);
      fidx++;
   endtask

   initial begin
      reset = 1'b1; hours = '0; minutes = '0; seconds = '0; hundredths = '0; ring = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_idle", {anodeSelect, segments, decimalPoint, frameStart}, idle_out());

      hours = 5'd12; minutes = 6'd34; seconds = 6'd56; hundredths = 7'd78;
      reset = 1'b0;
      frame("t123456_78");

      hours = 5'd5; minutes = 6'd10; seconds = 6'd0; hundredths = 7'd120;
      frame("clamp_blank");

      // Minutes change mid-scan must not tear the current frame
      push_frame(5, 10, 0, 120, 1'b0, fidx);
      run(20, "tear_a");
      minutes = 6'd11;
      run(FRAME_LEN - 20, "tear_b");
      fidx++;
      frame("tear_next");

      hours = 5'd23; minutes = 6'd63; seconds = 6'd60; hundredths = 7'd99;
      ring = 1'b1;
      repeat (4) frame("blink");
      ring = 1'b0;
      frame("steady");

      push_frame(23, 63, 60, 99, 1'b0, fidx);
      run(20, "pre_rst");
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      check("midreset_idle", {anodeSelect, segments, decimalPoint, frameStart}, idle_out());
      @(posedge clk);
      @(negedge clk);
      check("midreset_hold", {anodeSelect, segments, decimalPoint, frameStart}, idle_out());
      reset = 1'b0;
      fidx = 0;
      ring = 1'b1;
      hours = 5'd9; minutes = 6'd7; seconds = 6'd5; hundredths = 7'd3;
      repeat (4) frame("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
